// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard, forwarding and pipeline-control unit for the RV32 core. A
//   scoreboard of in-flight destinations FWD_DEPTH stages deep drives the
//   per-operand forwarding selects, load-use stalls, a taken-branch flush
//   window and a whole-pipeline freeze while data memory is not ready.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   id_valid     in   decode slot holds an instruction
//   id_rs1/rs2   in   source register indices
//   id_rs*_used  in   source is actually read
//   id_rd        in   destination index
//   id_reg_wr    in   instruction writes id_rd
//   id_is_load   in   instruction is a load
//   br_taken     in   decode instruction is a taken branch/jump
//   mem_req      in   memory stage has an access outstanding
//   mem_ready    in   data memory completes the access this cycle
//   fwd_a/fwd_b  out  operand source: 0 = register file, k = stage k result
//   issue        out  decode instruction advances this cycle
//   stall_f      out  hold PC and F/D
//   bubble_e     out  load a NOP into the next stage
//   flush_fd     out  kill the instruction being fetched into F/D
//   freeze       out  hold every pipeline register
module hazard_ctrl #(
  parameter int REG_INDEX_WIDTH = 5,
  parameter int FWD_DEPTH       = 2,
  parameter int LOAD_LAT        = 1,
  parameter int BR_PENALTY      = 1,
  localparam int FS             = $clog2(FWD_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [REG_INDEX_WIDTH-1:0] id_rs1,
  input  logic [REG_INDEX_WIDTH-1:0] id_rs2,
  input  logic                       id_rs1_used,
  input  logic                       id_rs2_used,
  input  logic [REG_INDEX_WIDTH-1:0] id_rd,
  input  logic                       id_reg_wr,
  input  logic                       id_is_load,
  input  logic                       br_taken,
  input  logic                       mem_req,
  input  logic                       mem_ready,
  output logic [FS-1:0]              fwd_a,
  output logic [FS-1:0]              fwd_b,
  output logic                       issue,
  output logic                       stall_f,
  output logic                       bubble_e,
  output logic                       flush_fd,
  output logic                       freeze
);

  // Scoreboard entry k describes the instruction issued k cycles ago.
  logic                       r_sb_v  [1:FWD_DEPTH];
  logic [REG_INDEX_WIDTH-1:0] r_sb_rd [1:FWD_DEPTH];
  logic                       r_sb_ld [1:FWD_DEPTH];
  logic [1:0]                 r_fcnt;

  logic [FS-1:0] w_fwd_a;
  logic [FS-1:0] w_fwd_b;
  logic          w_lu_a;
  logic          w_lu_b;
  logic          w_freeze;
  logic          w_issue;

  assign w_freeze = reset && mem_req && !mem_ready;

  // Nearest-producer lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    w_lu_a  = 1'b0;
    w_lu_b  = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (id_rs1_used && (id_rs1 != '0) && r_sb_v[k] && (r_sb_rd[k] == id_rs1)) begin
        w_fwd_a = FS'(k);
        w_lu_a  = r_sb_ld[k] && (k <= LOAD_LAT);
      end else begin
        w_fwd_a = w_fwd_a;
      end
      if (id_rs2_used && (id_rs2 != '0) && r_sb_v[k] && (r_sb_rd[k] == id_rs2)) begin
        w_fwd_b = FS'(k);
        w_lu_b  = r_sb_ld[k] && (k <= LOAD_LAT);
      end else begin
        w_fwd_b = w_fwd_b;
      end
    end
  end

  // Pipeline control in priority order: reset, freeze, flush window, load-use, issue.
  always_comb begin
    fwd_a    = '0;
    fwd_b    = '0;
    w_issue  = 1'b0;
    stall_f  = 1'b0;
    bubble_e = 1'b0;
    flush_fd = 1'b0;
    freeze   = 1'b0;
    if (!reset) begin
      w_issue = 1'b0;
    end else begin
      fwd_a = w_fwd_a;
      fwd_b = w_fwd_b;
      if (w_freeze) begin
        stall_f = 1'b1;
        freeze  = 1'b1;
      end else if (r_fcnt != 2'd0) begin
        // decode holds a wrong-path instruction: kill it and keep fetching
        bubble_e = 1'b1;
        flush_fd = 1'b1;
      end else if (id_valid && (w_lu_a || w_lu_b)) begin
        stall_f  = 1'b1;
        bubble_e = 1'b1;
      end else begin
        w_issue  = id_valid;
        // a branch only flushes on the cycle it actually issues
        flush_fd = id_valid && br_taken;
      end
    end
  end

  assign issue = w_issue;

  // Scoreboard shift and flush countdown; both hold while frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        r_sb_v[k]  <= 1'b0;
        r_sb_rd[k] <= '0;
        r_sb_ld[k] <= 1'b0;
      end
      r_fcnt <= 2'd0;
    end else if (!w_freeze) begin
      r_sb_v[1]  <= w_issue && id_reg_wr && (id_rd != '0);
      r_sb_rd[1] <= w_issue ? id_rd : '0;
      r_sb_ld[1] <= w_issue && id_is_load;
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        r_sb_v[k]  <= r_sb_v[k-1];
        r_sb_rd[k] <= r_sb_rd[k-1];
        r_sb_ld[k] <= r_sb_ld[k-1];
      end
      if (w_issue && br_taken) begin
        r_fcnt <= 2'(BR_PENALTY - 1);
      end else if (r_fcnt != 2'd0) begin
        r_fcnt <= r_fcnt - 2'd1;
      end else begin
        r_fcnt <= r_fcnt;
      end
    end else begin
      r_fcnt <= r_fcnt;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int RW = 5;
  localparam int FD = 2;
  localparam int FS = $clog2(FD + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs1 = '0;
  logic [RW-1:0] id_rs2 = '0;
  logic          id_rs1_used = 1'b0;
  logic          id_rs2_used = 1'b0;
  logic [RW-1:0] id_rd = '0;
  logic          id_reg_wr = 1'b0;
  logic          id_is_load = 1'b0;
  logic          br_taken = 1'b0;
  logic          mem_req = 1'b0;
  logic          mem_ready = 1'b0;
  logic [FS-1:0] fwd_a;
  logic [FS-1:0] fwd_b;
  logic          issue;
  logic          stall_f;
  logic          bubble_e;
  logic          flush_fd;
  logic          freeze;

  hazard_ctrl #(
    .REG_INDEX_WIDTH(RW),
    .FWD_DEPTH      (FD),
    .LOAD_LAT       (1),
    .BR_PENALTY     (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .id_rd      (id_rd),
    .id_reg_wr  (id_reg_wr),
    .id_is_load (id_is_load),
    .br_taken   (br_taken),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .issue      (issue),
    .stall_f    (stall_f),
    .bubble_e   (bubble_e),
    .flush_fd   (flush_fd),
    .freeze     (freeze)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [8:0] exp;  // {fwd_a, fwd_b, issue, stall_f, bubble_e, flush_fd, freeze}
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: one expected response per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t       e;
      logic [8:0] act;
      e   = q.pop_front();
      act = {fwd_a, fwd_b, issue, stall_f, bubble_e, flush_fd, freeze};
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got fa=%0d fb=%0d iss=%b stl=%b bub=%b fl=%b frz=%b, want fa=%0d fb=%0d iss=%b stl=%b bub=%b fl=%b frz=%b",
                 e.nm, act[8:7], act[6:5], act[4], act[3], act[2], act[1], act[0],
                 e.exp[8:7], e.exp[6:5], e.exp[4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  end

  // Apply one cycle of inputs and push the hand-computed response.
  task automatic step(input string nm, input bit rst, input bit v,
                      input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit wr, input bit ld, input bit br,
                      input bit mq, input bit mr,
                      input int efa, input int efb, input bit eis, input bit est,
                      input bit ebu, input bit efl, input bit efz);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    id_valid    = v;
    id_rs1      = rs1[RW-1:0];
    id_rs1_used = u1;
    id_rs2      = rs2[RW-1:0];
    id_rs2_used = u2;
    id_rd       = rd[RW-1:0];
    id_reg_wr   = wr;
    id_is_load  = ld;
    br_taken    = br;
    mem_req     = mq;
    mem_ready   = mr;
    e.nm  = nm;
    e.exp = {efa[1:0], efb[1:0], eis, est, ebu, efl, efz};
    q.push_back(e);
  endtask

  initial begin
    //   name        rst v  rs1 u1 rs2 u2 rd wr ld br mq mr  fa fb is st bu fl fz
    step("rst0",      0, 1,  5, 1,  5, 1, 5, 1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    step("rst1",      0, 1,  1, 1,  2, 1, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    step("add_x5",    1, 1,  1, 1,  2, 1, 5, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    step("sub_b2b",   1, 1,  5, 1,  5, 1, 6, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0);
    step("or_dist2",  1, 1,  5, 1,  0, 1, 7, 1, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 0);
    step("lw_x3",     1, 1,  2, 1,  0, 0, 3, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    step("lu_stall",  1, 1,  3, 1,  1, 1, 4, 1, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0);
    step("lu_issue",  1, 1,  3, 1,  1, 1, 4, 1, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 0);
    step("wr_x0",     1, 1,  1, 1,  0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    step("rd_x0_x4",  1, 1,  0, 1,  4, 1, 9, 1, 0, 0, 0, 0,  0, 2, 1, 0, 0, 0, 0);
    step("x9_again",  1, 1,  0, 0,  0, 0, 9, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    step("nearest",   1, 1,  9, 1,  9, 0,10, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    step("jal_iss",   1, 1,  0, 0,  0, 0, 1, 1, 0, 1, 0, 0,  0, 0, 1, 0, 0, 1, 0);
    step("jal_kill",  1, 1,  0, 0,  0, 0, 2, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0);
    step("jal2_iss",  1, 1,  0, 0,  0, 0,11, 1, 0, 1, 0, 0,  0, 0, 1, 0, 0, 1, 0);
    step("frz1",      1, 1,  0, 0,  0, 0, 3, 1, 0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 1);
    step("frz2",      1, 1,  0, 0,  0, 0, 3, 1, 0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 1);
    step("frz3",      1, 1,  0, 0,  0, 0, 3, 1, 0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 1);
    step("frz_rel",   1, 1,  0, 0,  0, 0, 3, 1, 0, 0, 1, 1,  0, 0, 0, 0, 1, 1, 0);
    step("sb_held",   1, 1, 11, 1,  0, 0,12, 1, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0, 0);
    step("lw_x8",     1, 1, 12, 1,  0, 0, 8, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    step("br_lu",     1, 1,  8, 1, 12, 1, 0, 0, 0, 1, 0, 0,  1, 2, 0, 1, 1, 0, 0);
    step("br_iss",    1, 1,  8, 1, 12, 1, 0, 0, 0, 1, 0, 0,  2, 0, 1, 0, 0, 1, 0);
    step("br_kill",   1, 1,  0, 0,  0, 0, 4, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0);
    step("br_frz",    1, 1,  0, 0,  0, 0, 1, 1, 0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 1);
    step("br_afrz",   1, 1,  0, 0,  0, 0, 1, 1, 0, 1, 1, 1,  0, 0, 1, 0, 0, 1, 0);
    step("br_kill2",  1, 1,  0, 0,  0, 0, 4, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0);
    step("p_x13",     1, 1,  0, 0,  0, 0,13, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    step("p_x14",     1, 1,  0, 0,  0, 0,14, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    step("full_frz",  1, 1,  0, 0,  0, 0,15, 1, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 1);
    step("rst_frz",   0, 1, 14, 1, 13, 1,15, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    step("post_rst",  1, 1, 14, 1, 13, 1,15, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    step("jal3_iss",  1, 1,  0, 0,  0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 1, 0);
    step("rst_flush", 0, 1,  0, 0,  0, 0, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    step("post_rst2", 1, 1, 15, 1,  0, 0, 5, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    step("idle",      1, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d responses still pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
